// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - register map constants and types for mmio_responder
// Shared by the responder top and its FIFO: register offsets decoded from
// address[2:0], CTRL/STATUS bit positions, and the register-select type.
package mmio_pkg;

  typedef logic [2:0] reg_sel_t;

  localparam reg_sel_t REG_GPIO_OUT = 3'd0;
  localparam reg_sel_t REG_GPIO_IN  = 3'd1;
  localparam reg_sel_t REG_CNT      = 3'd2;
  localparam reg_sel_t REG_CMP      = 3'd3;
  localparam reg_sel_t REG_CTRL     = 3'd4;
  localparam reg_sel_t REG_STATUS   = 3'd5;
  localparam reg_sel_t REG_CONS_TX  = 3'd6;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_IRQ_EN      = 1;
  localparam int CTRL_AUTO_RELOAD = 2;

  localparam int STAT_MATCH = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_COUNT = 4;

endpackage

// File: rtl/mmio_fifo.sv
// rtl/mmio_fifo.sv - circular synchronous FIFO for console output bytes
// Ports: clk, reset (async, active-high); push/push_data write side;
// pop request (ignored when empty); head = oldest entry; full, empty,
// count; ovf pulses for a push that was dropped because the FIFO was full.
module mmio_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rp];

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // accepted when it coincides with a valid pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign ovf     = push & full & ~do_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= push_data;
        wp      <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - memory-mapped GPIO, timer and console FIFO responder
// Ports: clk, reset (async, active-high); bus side sel/address/data_in/wren
// with registered data_out (1-cycle read latency); gpio_in (async) and
// gpio_out; console stream cons_data/cons_valid/cons_ready; irq from timer.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int GPIO_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wren,
  output logic [DATA_W-1:0] data_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [7:0]        cons_data,
  output logic              cons_valid,
  input  logic              cons_ready,
  output logic              irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  reg_sel_t          rsel;
  logic              wr;
  logic              rd;
  logic [GPIO_W-1:0] sync1;
  logic [GPIO_W-1:0] sync2;
  logic [DATA_W-1:0] cnt;
  logic [DATA_W-1:0] cmp;
  logic [2:0]        ctrl;
  logic              match;
  logic              ovf_flag;
  logic              hit;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              fifo_ovf;
  logic [DATA_W-1:0] rdata;
  logic              unused_addr;

  assign unused_addr = ^address[ADDR_W-1:3];

  assign rsel = address[2:0];
  assign wr   = sel & wren;
  assign rd   = sel & ~wren;
  assign hit  = ctrl[CTRL_EN] & (cnt == cmp);
  assign irq  = match & ctrl[CTRL_IRQ_EN];

  assign cons_valid = ~fifo_empty;

  mmio_fifo #(.DEPTH(FIFO_DEPTH), .W(8), .CW(CW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr && rsel == REG_CONS_TX),
    .push_data (data_in[7:0]),
    .pop       (cons_ready),
    .head      (cons_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .ovf       (fifo_ovf)
  );

  always_comb begin
    rdata = '0;
    case (rsel)
      REG_GPIO_OUT: rdata = DATA_W'(gpio_out);
      REG_GPIO_IN:  rdata = DATA_W'(sync2);
      REG_CNT:      rdata = cnt;
      REG_CMP:      rdata = cmp;
      REG_CTRL:     rdata = DATA_W'(ctrl);
      REG_STATUS: begin
        rdata[STAT_MATCH]             = match;
        rdata[STAT_FULL]              = fifo_full;
        rdata[STAT_EMPTY]             = fifo_empty;
        rdata[STAT_OVF]               = ovf_flag;
        rdata[STAT_COUNT +: 4]        = 4'(fifo_count);
      end
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      gpio_out <= '0;
      cnt      <= '0;
      cmp      <= '0;
      ctrl     <= '0;
      match    <= 1'b0;
      ovf_flag <= 1'b0;
      data_out <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;

      if (rd) data_out <= rdata;

      if (wr && rsel == REG_GPIO_OUT) gpio_out <= data_in[GPIO_W-1:0];
      if (wr && rsel == REG_CMP)      cmp      <= data_in;
      if (wr && rsel == REG_CTRL)     ctrl     <= data_in[2:0];

      // CPU write to CNT takes priority over counting and auto-reload.
      if (wr && rsel == REG_CNT)
        cnt <= data_in;
      else if (ctrl[CTRL_EN])
        cnt <= (hit && ctrl[CTRL_AUTO_RELOAD]) ? '0 : cnt + 1'b1;

      // A fresh match beats a same-cycle W1C.
      if (hit)
        match <= 1'b1;
      else if (wr && rsel == REG_STATUS && data_in[STAT_MATCH])
        match <= 1'b0;

      if (fifo_ovf)
        ovf_flag <= 1'b1;
      else if (wr && rsel == REG_STATUS && data_in[STAT_OVF])
        ovf_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// tb/tb_mmio_responder.sv - directed vector testbench for mmio_responder
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [9:0]  address;
  logic [31:0] data_in;
  logic        wren;
  logic [31:0] data_out;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic [7:0]  cons_data;
  logic        cons_valid;
  logic        cons_ready;
  logic        irq;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    bit          is_wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  mmio_responder dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .address    (address),
    .data_in    (data_in),
    .wren       (wren),
    .data_out   (data_out),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out),
    .cons_data  (cons_data),
    .cons_valid (cons_valid),
    .cons_ready (cons_ready),
    .irq        (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Tasks start right after a falling edge and end right after the next one.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    sel = 1'b1; wren = 1'b1; address = {7'd0, a}; data_in = d;
    @(negedge clk);
    sel = 1'b0; wren = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    sel = 1'b1; wren = 1'b0; address = {7'd0, a}; data_in = '0;
    @(negedge clk);
    sel = 1'b0;
    d = data_out;
  endtask

  task automatic add_vec(input bit w, input logic [2:0] a, input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] rv;
    int waited;

    for (int i = 0; i < 8; i++) add_vec(1'b0, 3'(i), 32'h0, (i == 5) ? 32'h4 : 32'h0);
    add_vec(1'b1, 3'd0, 32'h1A5, 32'h0);       add_vec(1'b0, 3'd0, 32'h0, 32'hA5);
    add_vec(1'b1, 3'd3, 32'hDEADBEEF, 32'h0);  add_vec(1'b0, 3'd3, 32'h0, 32'hDEADBEEF);
    add_vec(1'b1, 3'd2, 32'h12345678, 32'h0);  add_vec(1'b0, 3'd2, 32'h0, 32'h12345678);
    add_vec(1'b1, 3'd4, 32'hFFFFFFF8, 32'h0);  add_vec(1'b0, 3'd4, 32'h0, 32'h0);
    add_vec(1'b1, 3'd4, 32'h6, 32'h0);         add_vec(1'b0, 3'd4, 32'h0, 32'h6);
    add_vec(1'b1, 3'd4, 32'h0, 32'h0);         add_vec(1'b0, 3'd4, 32'h0, 32'h0);
    add_vec(1'b1, 3'd1, 32'hFF, 32'h0);        add_vec(1'b0, 3'd1, 32'h0, 32'h0);
    add_vec(1'b1, 3'd7, 32'hFFFF, 32'h0);      add_vec(1'b0, 3'd7, 32'h0, 32'h0);
    add_vec(1'b1, 3'd5, 32'hFFFFFFFF, 32'h0);  add_vec(1'b0, 3'd5, 32'h0, 32'h4);

    reset = 1'b1; sel = 1'b0; wren = 1'b0; address = '0; data_in = '0;
    gpio_in = 8'h00; cons_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_cons_valid", {31'd0, cons_valid}, 32'd0);
    check("reset_data_out", data_out, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      if (tbl[i].is_wr) bus_write(tbl[i].addr, tbl[i].data);
      else begin
        bus_read(tbl[i].addr, rv);
        check($sformatf("vec%0d_reg%0d", i, tbl[i].addr), rv, tbl[i].exp);
      end
    end
    check("gpio_out_pin", {24'd0, gpio_out}, 32'hA5);

    // GPIO input needs two synchroniser edges before it is readable.
    gpio_in = 8'h3C;
    bus_read(3'd1, rv); check("gpio_in_sync0", rv, 32'h0);
    bus_read(3'd1, rv); check("gpio_in_sync1", rv, 32'h0);
    bus_read(3'd1, rv); check("gpio_in_sync2", rv, 32'h3C);

    // Timer match with auto-reload.
    bus_write(3'd2, 32'd0);
    bus_write(3'd3, 32'd5);
    bus_write(3'd4, 32'h7);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("irq_low_cnt%0d", k), {31'd0, irq}, 32'd0);
    end
    @(negedge clk);
    check("irq_on_match", {31'd0, irq}, 32'd1);
    bus_read(3'd2, rv); check("cnt_reloaded", rv, 32'd0);
    bus_write(3'd5, 32'h1);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    waited = 0;
    while (!irq && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("irq_return_cycles", 32'(waited), 32'd4);

    // CPU write wins over increment; counter wraps.
    bus_write(3'd2, 32'h10);
    bus_read(3'd2, rv); check("cnt_write_wins", rv, 32'h10);
    bus_write(3'd2, 32'hFFFFFFFF);
    bus_read(3'd2, rv); check("cnt_max", rv, 32'hFFFFFFFF);
    bus_read(3'd2, rv); check("cnt_wrap", rv, 32'h0);
    bus_write(3'd4, 32'h0);
    bus_write(3'd5, 32'h9);
    check("irq_after_clear", {31'd0, irq}, 32'd0);

    // Fill FIFO past capacity.
    for (int b = 0; b < 5; b++) bus_write(3'd6, 32'h41 + 32'(b));
    bus_read(3'd5, rv); check("status_full_ovf", rv, 32'h4A);
    check("cons_head_full", {24'd0, cons_data}, 32'h41);
    cons_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      check($sformatf("drain_valid%0d", b), {31'd0, cons_valid}, 32'd1);
      check($sformatf("drain_data%0d", b), {24'd0, cons_data}, 32'h41 + 32'(b));
      @(negedge clk);
    end
    check("drain_empty", {31'd0, cons_valid}, 32'd0);
    cons_ready = 1'b0;
    bus_write(3'd5, 32'h8);
    bus_read(3'd5, rv); check("status_ovf_cleared", rv, 32'h4);

    // Push and pop on the same edge while full.
    for (int b = 0; b < 4; b++) bus_write(3'd6, 32'h61 + 32'(b));
    cons_ready = 1'b1;
    bus_write(3'd6, 32'h55);
    cons_ready = 1'b0;
    bus_read(3'd5, rv); check("status_push_pop_full", rv, 32'h42);
    check("head_after_push_pop", {24'd0, cons_data}, 32'h62);

    // Reset in the middle of draining.
    cons_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_mid_valid", {31'd0, cons_valid}, 32'd0);
    check("reset_mid_data_out", data_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cons_ready = 1'b0;
    bus_read(3'd5, rv); check("status_after_reset", rv, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
